// File: rtl/bank_cmd_arbiter.sv
// bank_cmd_arbiter: picks one DRAM command per cycle from a set of bank FSMs.
// Grant is combinational; the chosen command is registered onto cmd_* one cycle
// later. Per-bank tRCD/tRP windows, a bus-wide tCCD window and a tRFC blackout
// after refresh gate eligibility. Refresh always wins; among REFs the lowest
// bank index wins.
// Build option: define BANK_ARB_ROUND_ROBIN_EN for round-robin selection among
// non-REF requests; otherwise the lowest eligible index wins.
module bank_cmd_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_BITS = 16,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_CCD     = 2,
  parameter int T_RFC     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BANKS-1:0]           req,
  input  logic [3*NUM_BANKS-1:0]         cmd_in,
  input  logic [ADDR_BITS*NUM_BANKS-1:0] addr_in,
  output logic [NUM_BANKS-1:0]           grant,
  output logic [NUM_BANKS-1:0]           stall,
  output logic                           cmd_valid,
  output logic [2:0]                     cmd_out,
  output logic [$clog2(NUM_BANKS)-1:0]   cmd_bank,
  output logic [ADDR_BITS-1:0]           cmd_addr
);

  localparam int BW    = $clog2(NUM_BANKS);
  localparam int RCD_W = $clog2(T_RCD + 1);
  localparam int RP_W  = $clog2(T_RP + 1);
  localparam int CCD_W = $clog2(T_CCD + 1);
  localparam int RFC_W = $clog2(T_RFC + 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RUN  = 2'd1,
    ARB_RFC  = 2'd2
  } arb_state_t;

  arb_state_t            state_r;
  logic [RFC_W-1:0]      rfc_cnt_r;
  logic [RCD_W-1:0]      act_cnt_r [NUM_BANKS];
  logic [RP_W-1:0]       pre_cnt_r [NUM_BANKS];
  logic [CCD_W-1:0]      ccd_cnt_r;
`ifdef BANK_ARB_ROUND_ROBIN_EN
  logic [BW-1:0]         rr_ptr_r;
  logic [BW-1:0]         rr_idx_s;
`endif

  logic [2:0]            cmd_s  [NUM_BANKS];
  logic [ADDR_BITS-1:0]  addr_s [NUM_BANKS];
  logic [NUM_BANKS-1:0]  pend_s;
  logic [NUM_BANKS-1:0]  ref_elig_s;
  logic [NUM_BANKS-1:0]  oth_elig_s;
  logic [BW-1:0]         ref_idx_s;
  logic [BW-1:0]         oth_idx_s;
  logic [BW-1:0]         gnt_idx_s;
  logic                  gnt_any_s;
  logic                  gnt_ref_s;
  logic [2:0]            gnt_cmd_s;
  logic [ADDR_BITS-1:0]  gnt_addr_s;
  logic                  gnt_rw_s;

  // Unpack per-bank fields and classify each request as pending / eligible
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      cmd_s[b]      = cmd_in[3*b +: 3];
      addr_s[b]     = addr_in[ADDR_BITS*b +: ADDR_BITS];
      pend_s[b]     = 1'b0;
      ref_elig_s[b] = 1'b0;
      oth_elig_s[b] = 1'b0;
      if (req[b]) begin
        case (cmd_s[b])
          CMD_ACT: begin
            pend_s[b]     = 1'b1;
            oth_elig_s[b] = (pre_cnt_r[b] == '0);
          end
          CMD_RD, CMD_WR: begin
            pend_s[b]     = 1'b1;
            oth_elig_s[b] = (act_cnt_r[b] == '0) && (ccd_cnt_r == '0);
          end
          CMD_PRE: begin
            pend_s[b]     = 1'b1;
            oth_elig_s[b] = 1'b1;
          end
          CMD_REF: begin
            pend_s[b]     = 1'b1;
            ref_elig_s[b] = (pre_cnt_r[b] == '0);
          end
          default: begin
            pend_s[b]     = 1'b0;
          end
        endcase
      end else begin
        pend_s[b] = 1'b0;
      end
    end
  end

  // Winner selection: REF first (lowest index), then the non-REF policy
  always_comb begin
    ref_idx_s = '0;
    oth_idx_s = '0;
`ifdef BANK_ARB_ROUND_ROBIN_EN
    rr_idx_s  = '0;
`endif
    // Scan high to low so the last hit (lowest index / smallest offset) sticks.
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      ref_idx_s = ref_elig_s[i] ? BW'(i) : ref_idx_s;
`ifdef BANK_ARB_ROUND_ROBIN_EN
      rr_idx_s  = BW'((int'(rr_ptr_r) + i) % NUM_BANKS);
      oth_idx_s = oth_elig_s[rr_idx_s] ? rr_idx_s : oth_idx_s;
`else
      oth_idx_s = oth_elig_s[i] ? BW'(i) : oth_idx_s;
`endif
    end
    if (state_r == ARB_RFC) begin
      gnt_any_s = 1'b0;
      gnt_ref_s = 1'b0;
      gnt_idx_s = '0;
    end else if (|ref_elig_s) begin
      gnt_any_s = 1'b1;
      gnt_ref_s = 1'b1;
      gnt_idx_s = ref_idx_s;
    end else begin
      gnt_any_s = |oth_elig_s;
      gnt_ref_s = 1'b0;
      gnt_idx_s = oth_idx_s;
    end
  end

  assign gnt_cmd_s  = cmd_s[gnt_idx_s];
  assign gnt_addr_s = addr_s[gnt_idx_s];
  assign gnt_rw_s   = gnt_any_s && ((gnt_cmd_s == CMD_RD) || (gnt_cmd_s == CMD_WR));

  // One-hot grant, held low while reset is asserted; stall is the unserved requests
  always_comb begin
    grant = '0;
    if (gnt_any_s && rst_n) begin
      grant[gnt_idx_s] = 1'b1;
    end else begin
      grant = '0;
    end
    stall = req & ~grant;
  end

  // Arbiter FSM and refresh blackout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ARB_IDLE;
      rfc_cnt_r <= '0;
    end else begin
      case (state_r)
        ARB_IDLE, ARB_RUN: begin
          if (gnt_any_s && gnt_ref_s) begin
            state_r   <= ARB_RFC;
            rfc_cnt_r <= RFC_W'(T_RFC - 1);
          end else if (|pend_s) begin
            state_r   <= ARB_RUN;
          end else begin
            state_r   <= ARB_IDLE;
          end
        end
        ARB_RFC: begin
          if (rfc_cnt_r == '0) begin
            state_r <= (|pend_s) ? ARB_RUN : ARB_IDLE;
          end else begin
            rfc_cnt_r <= rfc_cnt_r - RFC_W'(1'b1);
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          rfc_cnt_r <= '0;
        end
      endcase
    end
  end

  // Per-bank tRCD / tRP windows; a grant load takes precedence over the decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        act_cnt_r[b] <= '0;
        pre_cnt_r[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (grant[b] && (cmd_s[b] == CMD_ACT)) begin
          act_cnt_r[b] <= RCD_W'(T_RCD - 1);
        end else if (act_cnt_r[b] != '0) begin
          act_cnt_r[b] <= act_cnt_r[b] - RCD_W'(1'b1);
        end
        if (grant[b] && (cmd_s[b] == CMD_PRE)) begin
          pre_cnt_r[b] <= RP_W'(T_RP - 1);
        end else if (pre_cnt_r[b] != '0) begin
          pre_cnt_r[b] <= pre_cnt_r[b] - RP_W'(1'b1);
        end
      end
    end
  end

  // Bus-wide tCCD window between column commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccd_cnt_r <= '0;
    end else if (gnt_rw_s) begin
      ccd_cnt_r <= CCD_W'(T_CCD - 1);
    end else if (ccd_cnt_r != '0) begin
      ccd_cnt_r <= ccd_cnt_r - CCD_W'(1'b1);
    end
  end

`ifdef BANK_ARB_ROUND_ROBIN_EN
  // Advance the round-robin pointer past each non-REF winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (gnt_any_s && !gnt_ref_s) begin
      rr_ptr_r <= (int'(gnt_idx_s) == NUM_BANKS - 1) ? '0 : gnt_idx_s + BW'(1'b1);
    end
  end
`endif

  // Register the granted command onto the DRAM command bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_out   <= CMD_NOP;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
    end else if (gnt_any_s) begin
      cmd_valid <= 1'b1;
      cmd_out   <= gnt_cmd_s;
      cmd_bank  <= gnt_idx_s;
      cmd_addr  <= gnt_addr_s;
    end else begin
      cmd_valid <= 1'b0;
      cmd_out   <= CMD_NOP;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
    end
  end

endmodule
